// File: rtl/adler32_ctrl.sv
// ---------------------------------------------------------------------------
// adler32_ctrl
//
// Sequencing controller for the Adler-32 checksum datapath. It takes a
// message length over a valid/ready handshake, then lets that many bytes
// flow into the datapath at up to one byte per cycle. When the last byte
// has been folded in, it presents the datapath's checksum through a
// valid/ready handshake. The checksum value and the byte counter live in
// the datapath; this block only sequences them through strobes.
//
// Ports:
//   clk             single clock, rising-edge
//   rst_n           asynchronous, active-low reset
//   size[31:0]      message length in bytes, sampled on the size handshake
//   size_valid      host presents size
//   size_ready      controller accepts size (IDLE)
//   data_valid      host presents a byte (the byte goes directly to datapath)
//   data_ready      controller accepts a byte (DATA)
//   abort           synchronous abandon of the current message
//   last_data       from datapath: byte counter == 1
//   latch_size      datapath strobe: load byte counter from size
//   clr_data        datapath strobe: A <= 1, B <= 0
//   upd_data        datapath strobe: fold current byte into A/B
//   dec_cnt         datapath strobe: decrement byte counter
//   checksum_valid  datapath checksum is final (DONE)
//   checksum_ready  host consumes the checksum
//   busy            controller is not IDLE
// ---------------------------------------------------------------------------
module adler32_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] size,
  input  logic        size_valid,
  output logic        size_ready,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        abort,
  input  logic        last_data,
  output logic        latch_size,
  output logic        clr_data,
  output logic        upd_data,
  output logic        dec_cnt,
  output logic        checksum_valid,
  input  logic        checksum_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // State register; reset drops straight back to IDLE without waiting for
  // a clock edge so an interrupted message is abandoned immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. Ready/valid/busy depend on state only, so
  // there is no combinational path from the host's valid inputs to our
  // ready outputs. The datapath strobes are decoded in the handshake cycle
  // itself because the datapath registers them on the same clock edge.
  always_comb begin
    next_state     = state;
    size_ready     = (state == IDLE);
    data_ready     = (state == DATA);
    checksum_valid = (state == DONE);
    busy           = (state != IDLE);
    latch_size     = 1'b0;
    clr_data       = 1'b0;
    upd_data       = 1'b0;
    dec_cnt        = 1'b0;

    case (state)
      // abort is ignored here: nothing is in flight to abandon, and a
      // coincident size handshake goes ahead normally.
      IDLE: begin
        if (size_valid) begin
          latch_size = 1'b1;
          clr_data   = 1'b1;
          // A zero-length message is already complete: the cleared
          // datapath holds the Adler-32 of the empty string.
          if (size == 32'd0) begin
            next_state = DONE;
          end else begin
            next_state = DATA;
          end
        end
      end

      // abort wins over a byte handshake, including the last one, and
      // clears A/B so a stale partial sum is never visible.
      DATA: begin
        if (abort) begin
          clr_data   = 1'b1;
          next_state = IDLE;
        end else if (data_valid) begin
          upd_data = 1'b1;
          dec_cnt  = 1'b1;
          if (last_data) begin
            next_state = DONE;
          end
        end
      end

      // No strobes while waiting, so the checksum stays stable until the
      // host takes it. abort wins over checksum_ready.
      DONE: begin
        if (abort) begin
          clr_data   = 1'b1;
          next_state = IDLE;
        end else if (checksum_ready) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adler32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adler32_ctrl
//
// Self-checking bench for adler32_ctrl. A small behavioural datapath
// (byte counter plus A/B sums) reacts to the controller's strobes so full
// messages can be run end to end; expected checksums come from a plain
// Adler-32 function over the message bytes, or from known constants.
// ---------------------------------------------------------------------------
module tb_adler32_ctrl;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] size = 32'd0;
  logic        size_valid = 1'b0;
  logic        size_ready;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        abort = 1'b0;
  logic        last_data;
  logic        latch_size;
  logic        clr_data;
  logic        upd_data;
  logic        dec_cnt;
  logic        checksum_valid;
  logic        checksum_ready = 1'b0;
  logic        busy;

  logic [7:0]  cur_byte = 8'd0;

  int total = 0;
  int bad = 0;
  int upd_pulses = 0;

  adler32_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .size           (size),
    .size_valid     (size_valid),
    .size_ready     (size_ready),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .abort          (abort),
    .last_data      (last_data),
    .latch_size     (latch_size),
    .clr_data       (clr_data),
    .upd_data       (upd_data),
    .dec_cnt        (dec_cnt),
    .checksum_valid (checksum_valid),
    .checksum_ready (checksum_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath driven by the controller's strobes.
  logic [31:0] dp_cnt = 32'd0;
  logic [31:0] dp_a = 32'd1;
  logic [31:0] dp_b = 32'd0;
  wire  [31:0] next_a = (dp_a + {24'd0, cur_byte}) % 32'd65521;
  wire  [31:0] checksum = {dp_b[15:0], dp_a[15:0]};

  assign last_data = (dp_cnt == 32'd1);

  always @(posedge clk) begin
    if (latch_size) begin
      dp_cnt <= size;
    end else if (dec_cnt) begin
      dp_cnt <= dp_cnt - 32'd1;
    end
    if (clr_data) begin
      dp_a <= 32'd1;
      dp_b <= 32'd0;
    end else if (upd_data) begin
      dp_a <= next_a;
      dp_b <= (dp_b + next_a) % 32'd65521;
    end
    if (upd_data === 1'b1) begin
      upd_pulses <= upd_pulses + 1;
    end
  end

  // Reference Adler-32 over a whole message.
  function automatic logic [31:0] adler32(input byte_q_t msg);
    longint a = 1;
    longint b = 0;
    foreach (msg[i]) begin
      a = (a + longint'(msg[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic byte_q_t firstN(input byte_q_t msg, input int n);
    byte_q_t r;
    for (int i = 0; i < n; i++) r.push_back(msg[i]);
    return r;
  endfunction

  task automatic applyStimulus(input logic sv, input logic [31:0] sz,
                               input logic dv, input logic [7:0] b,
                               input logic ab, input logic cr);
    size_valid     = sv;
    size           = sz;
    data_valid     = dv;
    cur_byte       = b;
    abort          = ab;
    checksum_ready = cr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Size handshake in the coming cycle.
  task automatic sendSize(input logic [31:0] sz, input logic ab, input string tag);
    @(negedge clk);
    applyStimulus(1'b1, sz, 1'b0, 8'd0, ab, 1'b0);
    #1;
    checkOutput({tag, ".size_ready"}, size_ready, 1);
    checkOutput({tag, ".latch_size"}, latch_size, 1);
    checkOutput({tag, ".clr_hs"}, clr_data, 1);
    checkOutput({tag, ".busy_idle"}, busy, 0);
  endtask

  // Stream bytes with random data_valid gaps; assumes state DATA.
  task automatic streamMsg(input byte_q_t msg, input int gap_pct, input string tag);
    int   idx = 0;
    int   cycles = 0;
    int   budget = 40 * msg.size() + 40;
    logic dv;
    while (idx < msg.size() && cycles < budget) begin
      @(negedge clk);
      dv = ($urandom_range(0, 99) >= gap_pct);
      applyStimulus(1'b0, 32'd0, dv, msg[idx], 1'b0, 1'b0);
      #1;
      checkOutput({tag, ".data_ready"}, data_ready, 1);
      checkOutput({tag, ".cv_early"}, checksum_valid, 0);
      checkOutput({tag, ".upd"}, upd_data, dv);
      checkOutput({tag, ".dec"}, dec_cnt, dv);
      if (dv) idx++;
      cycles++;
    end
    checkOutput({tag, ".bytes_taken"}, idx, msg.size());
  endtask

  // Hold checksum_ready low for 'hold' cycles, then complete the handshake.
  task automatic finishChecksum(input logic [31:0] exp, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, ".cv_hold"}, checksum_valid, 1);
      checkOutput({tag, ".sum_hold"}, checksum, exp);
      checkOutput({tag, ".clr_hold"}, clr_data, 0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    #1;
    checkOutput({tag, ".cv"}, checksum_valid, 1);
    checkOutput({tag, ".sum"}, checksum, exp);
    checkOutput({tag, ".data_ready_done"}, data_ready, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, ".idle_size_ready"}, size_ready, 1);
    checkOutput({tag, ".idle_cv"}, checksum_valid, 0);
    checkOutput({tag, ".idle_busy"}, busy, 0);
  endtask

  task automatic runMsg(input byte_q_t msg, input logic [31:0] exp,
                        input int gap_pct, input int hold, input string tag);
    int start_pulses = upd_pulses;
    sendSize(msg.size(), 1'b0, tag);
    if (msg.size() > 0) streamMsg(msg, gap_pct, tag);
    finishChecksum(exp, hold, tag);
    checkOutput({tag, ".upd_pulses"}, upd_pulses - start_pulses, msg.size());
  endtask

  initial begin
    byte_q_t     empty;
    byte_q_t     msg_a;
    byte_q_t     msg_b;
    byte_q_t     wiki;
    byte_q_t     rnd;
    logic [71:0] wiki_str = "Wikipedia";

    msg_a.push_back(8'h61);
    msg_b.push_back(8'h62);
    for (int i = 8; i >= 0; i--) wiki.push_back(wiki_str[i*8 +: 8]);

    // Reset state
    applyStimulus(1'b0, 32'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("rst.size_ready", size_ready, 1);
    checkOutput("rst.data_ready", data_ready, 0);
    checkOutput("rst.cv", checksum_valid, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.upd", upd_data, 0);
    checkOutput("rst.latch", latch_size, 0);
    #21 rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Zero-length message
    runMsg(empty, 32'h0000_0001, 0, 0, "size0");

    // Single byte
    runMsg(msg_a, 32'h0062_0062, 0, 0, "size1");

    // Wikipedia with gaps and a held-off checksum consumer
    runMsg(wiki, 32'h11E6_0398, 40, 5, "wiki");

    // Abort on the 4th byte
    sendSize(32'd9, 1'b0, "abort");
    streamMsg(firstN(wiki, 3), 0, "abort");
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b1, wiki[3], 1'b1, 1'b0);
    #1;
    checkOutput("abort.upd", upd_data, 0);
    checkOutput("abort.dec", dec_cnt, 0);
    checkOutput("abort.clr", clr_data, 1);
    checkOutput("abort.latch", latch_size, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("abort.idle_size_ready", size_ready, 1);
    checkOutput("abort.idle_busy", busy, 0);
    runMsg(msg_a, 32'h0062_0062, 0, 0, "after_abort");

    // Abort in DONE beats checksum_ready
    sendSize(32'd1, 1'b0, "abort_done");
    streamMsg(msg_a, 0, "abort_done");
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1);
    #1;
    checkOutput("abort_done.cv", checksum_valid, 1);
    checkOutput("abort_done.clr", clr_data, 1);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("abort_done.idle", size_ready, 1);
    checkOutput("abort_done.cleared", checksum, 32'h0000_0001);

    // Abort in IDLE does not disturb a coincident size handshake
    sendSize(32'd1, 1'b1, "abort_idle");
    streamMsg(msg_b, 0, "abort_idle");
    finishChecksum(32'h0063_0063, 0, "abort_idle");

    // Asynchronous reset mid-DATA
    sendSize(32'd9, 1'b0, "arst");
    streamMsg(firstN(wiki, 4), 0, "arst");
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b1, wiki[4], 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.busy", busy, 0);
    checkOutput("arst.data_ready", data_ready, 0);
    checkOutput("arst.size_ready", size_ready, 1);
    checkOutput("arst.upd", upd_data, 0);
    checkOutput("arst.dec", dec_cnt, 0);
    checkOutput("arst.cv", checksum_valid, 0);
    #1 rst_n = 1'b1;
    runMsg(wiki, 32'h11E6_0398, 25, 1, "after_arst");

    // Only the top bit set still counts as a non-zero size
    sendSize(32'h8000_0000, 1'b0, "bigsize");
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    #1;
    checkOutput("bigsize.data_ready", data_ready, 1);
    checkOutput("bigsize.cv", checksum_valid, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("bigsize.idle", size_ready, 1);

    // Back-to-back messages with checksum_ready tied high
    sendSize(32'd1, 1'b0, "b2b1");
    streamMsg(msg_a, 0, "b2b1");
    @(negedge clk);
    applyStimulus(1'b1, 32'd1, 1'b0, 8'd0, 1'b0, 1'b1);
    #1;
    checkOutput("b2b.cv1", checksum_valid, 1);
    checkOutput("b2b.sum1", checksum, 32'h0062_0062);
    checkOutput("b2b.no_size_ready", size_ready, 0);
    checkOutput("b2b.no_latch", latch_size, 0);
    @(negedge clk);
    applyStimulus(1'b1, 32'd1, 1'b0, 8'd0, 1'b0, 1'b1);
    #1;
    checkOutput("b2b.size_ready2", size_ready, 1);
    checkOutput("b2b.latch2", latch_size, 1);
    streamMsg(msg_b, 0, "b2b2");
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    #1;
    checkOutput("b2b.cv2", checksum_valid, 1);
    checkOutput("b2b.sum2", checksum, adler32(msg_b));
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("b2b.idle", size_ready, 1);

    // Random messages against the reference function
    for (int m = 0; m < 6; m++) begin
      rnd.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
        rnd.push_back(8'($urandom_range(0, 255)));
      end
      runMsg(rnd, adler32(rnd), 30, int'($urandom_range(0, 3)), $sformatf("rnd%0d", m));
    end

    $display("[TB] all directed and random steps issued");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
